vdic_dut_arbiter: RTL
=====================

VDIC_DUT_ARBITER -- requirements
Module: vdic_dut_arbiter

Interface
REQ-001 Parameter N_REQ, 4, number of client requesters (2..8).
REQ-002 Parameter TIMEOUT, 255, max cycles from issue to result before the transaction is aborted.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cl_req  input  N_REQ  per-client request level; held high until the matching cl_ack.
REQ-006 cl_arg_a  input  N_REQ*16  packed client A operands; client i occupies bits [16*i+15:16*i].
REQ-007 cl_arg_b  input  N_REQ*16  packed client B operands, same packing.
REQ-008 cl_ack  output  N_REQ  one-hot, one-cycle accept pulse.
REQ-009 cl_rsp_valid  output  N_REQ  one-hot, one-cycle response pulse to the granted client.
REQ-010 cl_result  output  32  result, valid with cl_rsp_valid.
REQ-011 cl_result_parity  output  1  DUT result parity, valid with cl_rsp_valid.
REQ-012 cl_parity_error  output  1  DUT argument parity error flag, valid with cl_rsp_valid.
REQ-013 cl_timeout  output  1  transaction aborted, valid with cl_rsp_valid.
REQ-014 dut_arg_a, dut_arg_b  output  16 each  operands to the DUT.
REQ-015 dut_arg_a_parity, dut_arg_b_parity  output  1 each  even parity (XOR of all 16 bits) of each operand.
REQ-016 dut_req  output  1  DUT request level.
REQ-017 dut_ack  input  1  DUT accept.
REQ-018 dut_result  input  32; dut_result_parity  input  1; dut_result_rdy  input  1; dut_arg_parity_error  input  1.

Function
REQ-019 The FSM has states IDLE, ISSUE, WAIT, RESP; all outputs are registered.
REQ-020 IDLE: when cl_req is non-zero, the block grants by round-robin, starting the search at (last_grant+1) mod N_REQ.
- Granting latches the client's operands and computed parities into dut_arg_*.
- cl_ack[g] pulses for exactly one cycle.
- Next state is ISSUE.
REQ-021 ISSUE: dut_req is high until dut_ack is sampled high.
- dut_req drops on the following cycle.
- Next state is WAIT.
- If dut_result_rdy is sampled high in the same cycle as dut_ack, the result is captured and the next state is RESP.
REQ-022 WAIT: on dut_result_rdy, the block captures dut_result, dut_result_parity and dut_arg_parity_error, then goes to RESP.
REQ-023 RESP: cl_rsp_valid[g] pulses for one cycle with the captured data; next state is IDLE.
- Net effect: one transaction in flight at a time.
REQ-024 dut_arg_* are stable from the cycle dut_req rises until dut_ack is sampled.
REQ-025 Timeout counter:
- clears on entry to ISSUE and increments each cycle in ISSUE or WAIT;
- on reaching TIMEOUT, the block drops dut_req and goes to RESP with cl_result=0, cl_result_parity=0, cl_parity_error=0, cl_timeout=1.
REQ-026 A result arriving in the same cycle as the timeout wins; cl_timeout=0.
REQ-027 A dut_result_rdy or dut_ack seen in IDLE or RESP is ignored.
REQ-028 A client whose cl_req is still high in the cycle after its cl_ack is treated as a new request.
REQ-029 cl_result, cl_result_parity, cl_parity_error and cl_timeout hold their last values between responses.
REQ-030 last_grant updates only on a grant; a single requesting client is granted back-to-back.

Reset
REQ-031 Asserting rst_n low immediately forces:
- state IDLE;
- all outputs 0;
- last_grant = N_REQ-1 (so client 0 has first priority);
- timeout counter 0.
REQ-032 Reset during ISSUE, WAIT or RESP abandons the transaction; no cl_rsp_valid is produced for it after reset.

Structure
REQ-033 A shared package vdic_arb_pkg holds:
- the state enum;
- ARG_W=16 and RES_W=32;
- a parity function.
REQ-034 Round-robin selection is a sub-module rr_arbiter (inputs: request vector, last_grant; output: one-hot grant); the FSM, counter and parity logic stay in vdic_dut_arbiter.

Verification
REQ-035 Single request: client 0 a=3, b=5; DUT model acks after 1 cycle and returns 15 after 3 cycles.
- Expect cl_ack[0] to pulse once.
- Expect dut_arg_a_parity=0 and dut_arg_b_parity=0.
- Expect cl_rsp_valid[0] with cl_result=15.
REQ-036 All four clients request together after reset, holding cl_req until acked.
- Expect grants in order 0,1,2,3.
- Client 2 then re-requests while 0 and 3 request: expect order 3, 0, 2.
REQ-037 Parity: client 1 a=16'h0001, b=16'hFFFF.
- Expect dut_arg_a_parity=1, dut_arg_b_parity=0.
REQ-038 The DUT model asserts dut_arg_parity_error together with dut_result_rdy.
- Expect cl_parity_error=1 in the cl_rsp_valid cycle.
REQ-039 TIMEOUT=16 and the DUT model never asserts dut_result_rdy.
- Expect cl_timeout=1, cl_result=0 and a cl_rsp_valid pulse 16 cycles after entering ISSUE.
- Expect a return to IDLE and acceptance of the next request.
REQ-040 rst_n is pulled low in WAIT.
- Expect all outputs 0 asynchronously.
- Expect no cl_rsp_valid afterwards.
- Expect a later request to be served normally.

Source files
------------

// File: rtl/vdic_arb_pkg.sv
// Shared types, widths and helpers for the DUT access arbiter.
package vdic_arb_pkg;

  localparam int ARG_W = 16;
  localparam int RES_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Even parity: XOR of all operand bits.
  function automatic logic parity_of(input logic [ARG_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from the client after
// last_grant (wrapping) and returns a one-hot grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int LG_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [LG_W-1:0]  last_grant,
  output logic [N_REQ-1:0] grant
);

  always_comb begin
    int  pos;
    logic found;
    grant = '0;
    found = 1'b0;
    pos   = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      pos = int'(last_grant) + off;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!found && req[LG_W'(pos)]) begin
        grant[LG_W'(pos)] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vdic_dut_arbiter.sv
// Shares one DUT among N_REQ clients: round-robin grant, single transaction in
// flight, registered outputs and a per-transaction timeout.
module vdic_dut_arbiter
  import vdic_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       cl_req,
  input  logic [N_REQ*ARG_W-1:0] cl_arg_a,
  input  logic [N_REQ*ARG_W-1:0] cl_arg_b,
  output logic [N_REQ-1:0]       cl_ack,
  output logic [N_REQ-1:0]       cl_rsp_valid,
  output logic [RES_W-1:0]       cl_result,
  output logic                   cl_result_parity,
  output logic                   cl_parity_error,
  output logic                   cl_timeout,
  output logic [ARG_W-1:0]       dut_arg_a,
  output logic [ARG_W-1:0]       dut_arg_b,
  output logic                   dut_arg_a_parity,
  output logic                   dut_arg_b_parity,
  output logic                   dut_req,
  input  logic                   dut_ack,
  input  logic [RES_W-1:0]       dut_result,
  input  logic                   dut_result_parity,
  input  logic                   dut_result_rdy,
  input  logic                   dut_arg_parity_error
);

  localparam int LG_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t state_reg, state_next;

  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [LG_W-1:0]  last_grant_reg, last_grant_next;
  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;

  logic [N_REQ-1:0] cl_ack_reg, cl_ack_next;
  logic [N_REQ-1:0] cl_rsp_valid_reg, cl_rsp_valid_next;
  logic [RES_W-1:0] cl_result_reg, cl_result_next;
  logic             cl_result_parity_reg, cl_result_parity_next;
  logic             cl_parity_error_reg, cl_parity_error_next;
  logic             cl_timeout_reg, cl_timeout_next;
  logic [ARG_W-1:0] dut_arg_a_reg, dut_arg_a_next;
  logic [ARG_W-1:0] dut_arg_b_reg, dut_arg_b_next;
  logic             dut_arg_a_parity_reg, dut_arg_a_parity_next;
  logic             dut_arg_b_parity_reg, dut_arg_b_parity_next;
  logic             dut_req_reg, dut_req_next;

  logic [N_REQ-1:0] rr_grant;
  logic [LG_W-1:0]  rr_idx;
  logic [ARG_W-1:0] arg_a_arr [N_REQ];
  logic [ARG_W-1:0] arg_b_arr [N_REQ];
  logic [ARG_W-1:0] sel_a, sel_b;
  logic             tmo_hit, capture, abort;

  rr_arbiter #(.N_REQ(N_REQ), .LG_W(LG_W)) u_rr (
    .req        (cl_req),
    .last_grant (last_grant_reg),
    .grant      (rr_grant)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign arg_a_arr[gi] = cl_arg_a[ARG_W*gi +: ARG_W];
    assign arg_b_arr[gi] = cl_arg_b[ARG_W*gi +: ARG_W];
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    rr_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_grant[i]) begin
        sel_a  = sel_a | arg_a_arr[i];
        sel_b  = sel_b | arg_b_arr[i];
        rr_idx = LG_W'(i);
      end
    end
  end

  // A result in the same cycle as the timeout takes precedence.
  assign tmo_hit = (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign capture = ((state_reg == ST_ISSUE) && dut_ack && dut_result_rdy) ||
                   ((state_reg == ST_WAIT) && dut_result_rdy);
  assign abort   = ((state_reg == ST_ISSUE) || (state_reg == ST_WAIT)) && !capture && tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg            <= ST_IDLE;
      grant_reg            <= '0;
      last_grant_reg       <= LG_W'(N_REQ - 1);
      tmo_cnt_reg          <= '0;
      cl_ack_reg           <= '0;
      cl_rsp_valid_reg     <= '0;
      cl_result_reg        <= '0;
      cl_result_parity_reg <= 1'b0;
      cl_parity_error_reg  <= 1'b0;
      cl_timeout_reg       <= 1'b0;
      dut_arg_a_reg        <= '0;
      dut_arg_b_reg        <= '0;
      dut_arg_a_parity_reg <= 1'b0;
      dut_arg_b_parity_reg <= 1'b0;
      dut_req_reg          <= 1'b0;
    end else begin
      state_reg            <= state_next;
      grant_reg            <= grant_next;
      last_grant_reg       <= last_grant_next;
      tmo_cnt_reg          <= tmo_cnt_next;
      cl_ack_reg           <= cl_ack_next;
      cl_rsp_valid_reg     <= cl_rsp_valid_next;
      cl_result_reg        <= cl_result_next;
      cl_result_parity_reg <= cl_result_parity_next;
      cl_parity_error_reg  <= cl_parity_error_next;
      cl_timeout_reg       <= cl_timeout_next;
      dut_arg_a_reg        <= dut_arg_a_next;
      dut_arg_b_reg        <= dut_arg_b_next;
      dut_arg_a_parity_reg <= dut_arg_a_parity_next;
      dut_arg_b_parity_reg <= dut_arg_b_parity_next;
      dut_req_reg          <= dut_req_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (|cl_req) state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (capture || abort) state_next = ST_RESP;
        else if (dut_ack)     state_next = ST_WAIT;
      end
      ST_WAIT:  if (capture || abort) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_next            = grant_reg;
    last_grant_next       = last_grant_reg;
    tmo_cnt_next          = tmo_cnt_reg;
    cl_ack_next           = '0;
    cl_rsp_valid_next     = '0;
    cl_result_next        = cl_result_reg;
    cl_result_parity_next = cl_result_parity_reg;
    cl_parity_error_next  = cl_parity_error_reg;
    cl_timeout_next       = cl_timeout_reg;
    dut_arg_a_next        = dut_arg_a_reg;
    dut_arg_b_next        = dut_arg_b_reg;
    dut_arg_a_parity_next = dut_arg_a_parity_reg;
    dut_arg_b_parity_next = dut_arg_b_parity_reg;
    dut_req_next          = dut_req_reg;

    case (state_reg)
      ST_IDLE: begin
        if (|cl_req) begin
          grant_next            = rr_grant;
          last_grant_next       = rr_idx;
          cl_ack_next           = rr_grant;
          dut_arg_a_next        = sel_a;
          dut_arg_b_next        = sel_b;
          dut_arg_a_parity_next = parity_of(sel_a);
          dut_arg_b_parity_next = parity_of(sel_b);
          dut_req_next          = 1'b1;
          tmo_cnt_next          = '0;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        tmo_cnt_next = tmo_cnt_reg + CNT_W'(1);
        if (dut_ack || abort) dut_req_next = 1'b0;
        if (capture) begin
          cl_rsp_valid_next     = grant_reg;
          cl_result_next        = dut_result;
          cl_result_parity_next = dut_result_parity;
          cl_parity_error_next  = dut_arg_parity_error;
          cl_timeout_next       = 1'b0;
        end else if (abort) begin
          cl_rsp_valid_next     = grant_reg;
          cl_result_next        = '0;
          cl_result_parity_next = 1'b0;
          cl_parity_error_next  = 1'b0;
          cl_timeout_next       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cl_ack           = cl_ack_reg;
  assign cl_rsp_valid     = cl_rsp_valid_reg;
  assign cl_result        = cl_result_reg;
  assign cl_result_parity = cl_result_parity_reg;
  assign cl_parity_error  = cl_parity_error_reg;
  assign cl_timeout       = cl_timeout_reg;
  assign dut_arg_a        = dut_arg_a_reg;
  assign dut_arg_b        = dut_arg_b_reg;
  assign dut_arg_a_parity = dut_arg_a_parity_reg;
  assign dut_arg_b_parity = dut_arg_b_parity_reg;
  assign dut_req          = dut_req_reg;

endmodule
